// File: rtl/rsff_seq.sv
// Sequencer turning single-cycle set/clear requests into guarded active-low pulses for a NAND SR latch.
// Optional readback checker enabled by defining RSFF_SEQ_CHECK_EN.
module rsff_seq #(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic latch_q,
    output logic set_n,
    output logic clr_n,
    output logic busy,
    output logic done,
    output logic q_exp,
    output logic err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SET_P = 2'd1;
    localparam logic [1:0] ST_CLR_P = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pend_set_r;
    logic             pend_clr_r;
    logic             pend_set_nxt_s;
    logic             pend_clr_nxt_s;
    logic             q_exp_r;
    logic             q_exp_nxt_s;
    logic             done_nxt_s;
    logic             set_n_r;
    logic             clr_n_r;
    logic             busy_r;
    logic             done_r;

    // Next-state decode; clear wins over set so a simultaneous pair nets q=1.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        pend_set_nxt_s = pend_set_r | set_req;
        pend_clr_nxt_s = pend_clr_r | clr_req;
        q_exp_nxt_s    = q_exp_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_clr_nxt_s) begin
                    state_nxt_s    = ST_CLR_P;
                    cnt_nxt_s      = PULSE_LD;
                    pend_clr_nxt_s = 1'b0;
                end else if (pend_set_nxt_s) begin
                    state_nxt_s    = ST_SET_P;
                    cnt_nxt_s      = PULSE_LD;
                    pend_set_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s      = CNT_ZERO;
                end
            end
            ST_SET_P, ST_CLR_P: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_GUARD;
                    cnt_nxt_s   = GUARD_LD;
                    q_exp_nxt_s = (state_r == ST_SET_P);
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_GUARD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        done_nxt_s = (state_nxt_s == ST_GUARD) && (cnt_nxt_s == CNT_ZERO);
    end

    // State, counter, pending flags and outputs, all registered from next-state values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            pend_set_r <= 1'b0;
            pend_clr_r <= 1'b0;
            q_exp_r    <= 1'b0;
            set_n_r    <= 1'b1;
            clr_n_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            pend_set_r <= pend_set_nxt_s;
            pend_clr_r <= pend_clr_nxt_s;
            q_exp_r    <= q_exp_nxt_s;
            set_n_r    <= (state_nxt_s != ST_SET_P);
            clr_n_r    <= (state_nxt_s != ST_CLR_P);
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= done_nxt_s;
        end
    end

    assign set_n = set_n_r;
    assign clr_n = clr_n_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign q_exp = q_exp_r;

`ifdef RSFF_SEQ_CHECK_EN
    logic sync1_r;
    logic sync2_r;
    logic err_r;

    // Resynchronise latch_q and latch a readback mismatch so err is visible in the done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            sync1_r <= latch_q;
            sync2_r <= sync1_r;
            err_r   <= err_r | (done_nxt_s & (sync2_r ^ q_exp_nxt_s));
        end
    end

    assign err = err_r;
`else
    logic unused_latch_q_s;
    assign unused_latch_q_s = latch_q;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rsff_seq.sv
// Self-checking bench for rsff_seq: a monitor records pulse/done events, tasks push expectations and compare.
module tb_rsff_seq;

    localparam int PW = 2;
    localparam int GW = 1;
    localparam int EV_SET  = 16;
    localparam int EV_CLR  = 32;
    localparam int EV_DONE = 48;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic latch_q = 1'b0;
    logic stuck0 = 1'b0;
    logic set_n, clr_n, busy, done, q_exp, err;

    int n_checks = 0;
    int n_fail = 0;
    int both_low_cnt = 0;
    int set_w = 0;
    int clr_w = 0;
    int exp_q[$];
    int obs_q[$];

    rsff_seq #(.PULSE_W(PW), .GUARD_W(GW), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .set_req(set_req), .clr_req(clr_req),
        .latch_q(latch_q), .set_n(set_n), .clr_n(clr_n), .busy(busy),
        .done(done), .q_exp(q_exp), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural NAND latch, optionally stuck at 0.
    always @(set_n or clr_n or stuck0) begin
        if (stuck0) latch_q = 1'b0;
        else if (!set_n) latch_q = 1'b1;
        else if (!clr_n) latch_q = 1'b0;
    end

    // Monitor: record completed pulse widths and done events; count overlap of drives.
    always @(negedge clk) begin
        if (set_n === 1'b0 && clr_n === 1'b0) both_low_cnt = both_low_cnt + 1;
        if (!reset_n) begin
            set_w = 0;
            clr_w = 0;
        end else begin
            if (!set_n) set_w = set_w + 1;
            else if (set_w != 0) begin obs_q.push_back(EV_SET + set_w); set_w = 0; end
            if (!clr_n) clr_w = clr_w + 1;
            else if (clr_w != 0) begin obs_q.push_back(EV_CLR + clr_w); clr_w = 0; end
            if (done) obs_q.push_back(EV_DONE + int'(q_exp));
        end
    end

    task automatic test_reset();
        int e, o;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({set_n, clr_n, busy, done, q_exp, err} !== 6'b110000) begin
            n_fail++; $display("FAIL reset_state got=%b want=110000", {set_n, clr_n, busy, done, q_exp, err});
        end
        reset_n = 1'b1;
        @(negedge clk);
        clr_req = 1'b1;
        exp_q.push_back(EV_CLR + PW); exp_q.push_back(EV_DONE + 0);
        @(negedge clk);
        clr_req = 1'b0;
        n_checks++;
        if (clr_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reset_clr_t1 clr_n=%b busy=%b want 0/1", clr_n, busy); end
        @(negedge clk);
        n_checks++;
        if (clr_n !== 1'b0) begin n_fail++; $display("FAIL reset_clr_t2 clr_n=%b want 0", clr_n); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || clr_n !== 1'b1) begin n_fail++; $display("FAIL reset_done_t3 done=%b clr_n=%b want 1/1", done, clr_n); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q_exp !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_t4 busy=%b done=%b q_exp=%b want 0/0/0", busy, done, q_exp);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_sb got=%0d want=%0d", o, e); end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_sb_extra got=%0d events want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_both_same_cycle();
        logic exp_set [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_clr [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int e, o;
        both_low_cnt = 0;
        @(negedge clk);
        set_req = 1'b1; clr_req = 1'b1;
        exp_q.push_back(EV_CLR + PW); exp_q.push_back(EV_DONE + 0);
        exp_q.push_back(EV_SET + PW); exp_q.push_back(EV_DONE + 1);
        @(negedge clk);
        set_req = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({set_n, clr_n, done} !== {exp_set[i], exp_clr[i], exp_done[i]}) begin
                n_fail++;
                $display("FAIL both_trace cyc=%0d got set_n/clr_n/done=%b want=%b", i + 1,
                         {set_n, clr_n, done}, {exp_set[i], exp_clr[i], exp_done[i]});
            end
        end
        n_checks++;
        if (q_exp !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL both_final q_exp=%b busy=%b want 1/0", q_exp, busy); end
        n_checks++;
        if (both_low_cnt != 0) begin n_fail++; $display("FAIL both_overlap got=%0d want=0", both_low_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL both_sb got=%0d want=%0d", o, e); end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL both_sb_extra got=%0d events want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_merge();
        int e, o;
        @(negedge clk);
        clr_req = 1'b1;
        exp_q.push_back(EV_CLR + PW); exp_q.push_back(EV_DONE + 0);
        exp_q.push_back(EV_SET + PW); exp_q.push_back(EV_DONE + 1);
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req = 1'b1;
            @(negedge clk);
        end
        set_req = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || q_exp !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL merge_final busy=%b q_exp=%b err=%b want 0/1/0", busy, q_exp, err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL merge_sb got=%0d want=%0d", o, e); end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL merge_sb_extra got=%0d events want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid_pulse();
        @(negedge clk);
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        clr_req = 1'b1;
        n_checks++;
        if (set_n !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_low set_n=%b want 0", set_n); end
        @(posedge clk);
        #2;
        clr_req = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (set_n !== 1'b1 || clr_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_async set_n=%b clr_n=%b busy=%b want 1/1/0", set_n, clr_n, busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || busy !== 1'b0 || q_exp !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_resume events=%0d busy=%b q_exp=%b want 0/0/0", obs_q.size(), busy, q_exp);
            obs_q.delete();
        end
    endtask

    task automatic test_check();
        int e, o;
        @(negedge clk);
        stuck0 = 1'b1;
        set_req = 1'b1;
        exp_q.push_back(EV_SET + PW); exp_q.push_back(EV_DONE + 1);
        @(negedge clk);
        set_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
`ifdef RSFF_SEQ_CHECK_EN
            n_checks++;
            if (err !== (i >= PW + GW)) begin n_fail++; $display("FAIL check_err cyc=%0d got=%b want=%b", i, err, (i >= PW + GW)); end
`else
            n_checks++;
            if (err !== 1'b0) begin n_fail++; $display("FAIL check_err_off cyc=%0d got=%b want=0", i, err); end
`endif
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL check_sb got=%0d want=%0d", o, e); end
        end
        obs_q.delete();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL check_err_reset got=%b want=0", err); end
        reset_n = 1'b1;
        stuck0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_both_same_cycle();
        test_merge();
        test_reset_mid_pulse();
        test_check();
        n_checks++;
        if (both_low_cnt != 0) begin n_fail++; $display("FAIL overlap_total got=%0d want=0", both_low_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
